stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- N-channel, parametrised-width streaming multiplexer with a valid/ready handshake on every port.
- Replaces select-driven muxing where multiple producers (e.g. neuron-layer partial-sum units) contend for one consumer.
- Internal arbitration is fixed-priority or round-robin. Packet lock holds a grant until the packet ends.
- A single output register stage makes the output fully registered.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels (>=1).
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- LOCK, 1, 1 = grant held from first to last beat of a packet; 0 = re-arbitrate every beat.
- SELW (localparam), max(1, clog2(N)), width of channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel end-of-packet flag.
- in_ready  output  N  per-channel accept.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_sel  output  SELW  index of the channel that sourced the current out beat.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - locked=0.
  - rr_ptr=N-1, so channel 0 has top priority after reset.
- adv = !out_valid || out_ready. The output register may load when adv=1.
- Grant (combinational, one-hot or zero):
  - locked=1: grant = lock_ch, regardless of other valids.
  - locked=0, MODE=0: lowest-index asserted in_valid.
  - locked=0, MODE=1: first asserted in_valid scanning rr_ptr+1, rr_ptr+2, ... wrapping modulo N.
  - No in_valid asserted: grant=0.
- in_ready[i] = grant[i] && adv. At most one bit is set.
- in_ready may depend on in_valid. Producers must not wait for ready before asserting valid.
- Accept = |(in_valid & in_ready). On accept, the next edge loads:
  - out_data = in_data[g], out_last = in_last[g], out_sel = g, out_valid = 1.
- No accept and out_ready=1: out_valid clears to 0. out_data, out_last and out_sel hold their stale values.
- out_valid=1 and out_ready=0: out_data, out_last, out_sel and out_valid are all stable (no change).
- Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- rr_ptr updates to g on every accept (MODE=1 only; ignored in MODE=0).
- Lock FSM (LOCK=1), states IDLE (locked=0) and PKT (locked=1):
  - IDLE -> PKT on accept with in_last[g]=0; lock_ch = g.
  - PKT -> IDLE on accept of a beat from lock_ch with in_last=1.
  - IDLE stays IDLE on accept with in_last[g]=1 (single-beat packet).
  - In PKT, if lock_ch drops valid, no other channel is granted. Bubbles are allowed.
  - LOCK=0: locked is tied 0.
- N=1: grant = in_valid[0]; out_sel is always 0; rr_ptr unused.
- Reset mid-packet: lock is lost, the output is emptied and the in-flight beat is dropped. Upstream must reset coherently.
- Channel data for non-granted channels is never sampled. X on non-granted in_data must not propagate.

Decomposition:
- Shared include stream_defs.vh holds:
  - MODE_FIXED=0, MODE_RR=1.
  - A clog2 constant function, reused by other NNSimulator stream blocks.
- One sub-module, stream_rr_arbiter (params N, MODE):
  - Inputs: req[N-1:0], ptr, lock, lock_ch.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational; rr_ptr, the lock FSM and the output register live in stream_mux_arb.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Release with in_valid=4'b1111, all last=1 -> first out_sel=0, then 1,2,3,0 on consecutive cycles (MODE=1).
- Fixed priority (MODE=0): in_valid=4'b1010 continuous, last=1 -> out_sel=1 every cycle; channel 3 is never granted.
- Backpressure: 2 beats in flight, out_ready=0 for 5 cycles -> out_data/out_sel/out_valid stable; in_ready=0000. Release -> next beat 1 cycle later, no loss or duplicate.
- Packet lock: ch2 sends 3 beats (last on beat 3) while ch0/ch1 valid; ch2 drops valid for 2 cycles mid-packet -> only ch2 granted until its last beat, then rr_ptr=2 so ch3 (if valid) else ch0 is next.
- LOCK=0 same stimulus -> beats interleave per round-robin; out_last carries each source's flag unchanged.
- Async reset asserted mid-packet with out_valid=1 -> out_valid=0 immediately (before the next edge); after release, arbitration starts from ch0 and is unlocked.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// rtl/stream_mux_arb_pkg.sv - shared constants, lock-state type and width helpers for stream blocks
package stream_mux_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } lock_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // A single channel still needs a one-bit index port.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - combinational fixed-priority / round-robin grant with lock override
module stream_rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int MODE = MODE_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            lock,
    input  logic [SELW-1:0] lock_ch,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        if (lock) begin
            // A locked packet owns the output; an idle owner yields a bubble, never another channel.
            for (int i = 0; i < N; i++) begin
                if ((int'(lock_ch) == i) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else if (MODE == MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i]) begin
                    w_found   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            // Scan starts one past the last winner so it has lowest priority next time.
            for (int s = 1; s <= N; s++) begin
                if (!w_found && req[(int'(ptr) + s) % N]) begin
                    w_found                    = 1'b1;
                    grant[(int'(ptr) + s) % N] = 1'b1;
                    grant_idx                  = SELW'((int'(ptr) + s) % N);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel valid/ready stream mux with arbitration, packet lock and registered output
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_RR,
    parameter  int LOCK  = 1,
    localparam int SELW  = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_rr_ptr;
    logic [SELW-1:0]  r_lock_ch;
    lock_state_t      r_state;

    logic             w_adv;
    logic             w_locked;
    logic             w_accept;
    logic [N-1:0]     w_grant;
    logic [SELW-1:0]  w_gidx;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;

    assign w_adv    = !r_out_valid || out_ready;
    assign w_locked = (LOCK != 0) && (r_state == ST_PKT);

    stream_rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .lock      (w_locked),
        .lock_ch   (r_lock_ch),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    // Ready is held low while reset is asserted so nothing is consumed that the output cannot keep.
    assign in_ready = w_grant & {N{w_adv & rst_n}};
    assign w_accept = |(in_valid & in_ready);

    // AND-OR selection: non-granted channel data is masked to zero and cannot leak through.
    always_comb begin
        w_mux_data = '0;
        w_mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            w_mux_last = w_mux_last | (in_last[i] & w_grant[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_mux_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_mux_last;
            r_out_sel   <= w_gidx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer resets to the top index so channel 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= SELW'(N - 1);
        end else if ((MODE == MODE_RR) && w_accept) begin
            r_rr_ptr <= w_gidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else if ((LOCK != 0) && w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_mux_last) begin
                        r_state   <= ST_PKT;
                        r_lock_ch <= w_gidx;
                    end
                end
                ST_PKT: begin
                    if (w_mux_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - randomized self-checking bench for stream_mux_arb in three configurations
module tb_stream_mux_arb;
    import stream_mux_arb_pkg::*;

    localparam int W    = 32;
    localparam int N    = 4;
    localparam int NI   = 3;
    localparam int SELW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic           out_ready;

    logic [N-1:0]    rdy [NI];
    logic [W-1:0]    od  [NI];
    logic            ov  [NI];
    logic            ol  [NI];
    logic [SELW-1:0] os  [NI];

    int cfg_mode [NI] = '{1, 0, 1};
    int cfg_lock [NI] = '{1, 1, 0};

    bit         m_ov     [NI];
    logic [W-1:0] m_od   [NI];
    bit         m_ol     [NI];
    int         m_os     [NI];
    bit         m_locked [NI];
    int         m_lch    [NI];
    int         m_ptr    [NI];

    int n_checks = 0;
    int n_errors = 0;

    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(1), .LOCK(1)) u_rr_lock (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_sel(os[0]),
        .out_ready(out_ready));
    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(0), .LOCK(1)) u_fix_lock (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_sel(os[1]),
        .out_ready(out_ready));
    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(1), .LOCK(0)) u_rr_nolock (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy[2]), .out_data(od[2]), .out_valid(ov[2]), .out_last(ol[2]), .out_sel(os[2]),
        .out_ready(out_ready));

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_ov[k] = 0; m_od[k] = '0; m_ol[k] = 0; m_os[k] = 0;
            m_locked[k] = 0; m_lch[k] = 0; m_ptr[k] = N - 1;
        end
    endfunction

    function automatic int model_grant(int k);
        int c;
        if (m_locked[k]) return in_valid[m_lch[k]] ? m_lch[k] : -1;
        for (int s = 0; s < N; s++) begin
            c = (cfg_mode[k] == 0) ? s : (m_ptr[k] + 1 + s) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(int k);
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant(k);
        if (rst_n && g >= 0 && (!m_ov[k] || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_edge();
        int g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            g = model_grant(k);
            if (g >= 0 && (!m_ov[k] || out_ready)) begin
                m_ov[k] = 1; m_od[k] = in_data[g*W +: W]; m_ol[k] = in_last[g]; m_os[k] = g;
                if (cfg_mode[k] == 1) m_ptr[k] = g;
                if (cfg_lock[k] == 1) begin
                    if (!m_locked[k] && !in_last[g]) begin
                        m_locked[k] = 1; m_lch[k] = g;
                    end else if (m_locked[k] && in_last[g]) begin
                        m_locked[k] = 0;
                    end
                end
            end else if (out_ready) begin
                m_ov[k] = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            drive(N'($urandom), N'($urandom), 1'($urandom));
            #1;
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (ov[k] !== 1'b0 || od[k] !== '0 || os[k] !== '0 || rdy[k] !== '0) begin
                    n_errors++;
                    $display("FAIL reset_state inst%0d: got v=%0b d=%h s=%0d rdy=%b expected all zero",
                             k, ov[k], od[k], os[k], rdy[k]);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b1);
            tick();
            n_checks++;
            if (ov[0] !== 1'b1 || os[0] !== SELW'(i % 4) || od[0] !== in_data[(i % 4)*W +: W]) begin
                n_errors++;
                $display("FAIL reset_rr_order beat%0d: got v=%0b sel=%0d d=%h expected v=1 sel=%0d d=%h",
                         i, ov[0], os[0], od[0], i % 4, in_data[(i % 4)*W +: W]);
            end
        end
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1010, 4'b1111, 1'b1);
            #1;
            n_checks++;
            if (rdy[1] !== 4'b0010) begin
                n_errors++;
                $display("FAIL fixed_ready cycle%0d: got %b expected 0010", i, rdy[1]);
            end
            tick();
            n_checks++;
            if (ov[1] !== 1'b1 || os[1] !== 2'd1 || od[1] !== in_data[W +: W]) begin
                n_errors++;
                $display("FAIL fixed_sel cycle%0d: got v=%0b sel=%0d d=%h expected v=1 sel=1 d=%h",
                         i, ov[1], os[1], od[1], in_data[W +: W]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] snap_d;
        int           snap_s;
        int           nxt;
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        snap_d = m_od[0];
        snap_s = m_os[0];
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            #1;
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (rdy[k] !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL stall_ready inst%0d cycle%0d: got %b expected 0000", k, i, rdy[k]);
                end
            end
            tick();
            n_checks++;
            if (ov[0] !== 1'b1 || od[0] !== snap_d || os[0] !== SELW'(snap_s)) begin
                n_errors++;
                $display("FAIL stall_hold cycle%0d: got v=%0b d=%h s=%0d expected v=1 d=%h s=%0d",
                         i, ov[0], od[0], os[0], snap_d, snap_s);
            end
        end
        drive(4'b1111, 4'b1111, 1'b1);
        nxt = (snap_s + 1) % N;
        tick();
        n_checks++;
        if (ov[0] !== 1'b1 || os[0] !== SELW'(nxt) || od[0] !== in_data[nxt*W +: W]) begin
            n_errors++;
            $display("FAIL stall_release: got v=%0b s=%0d d=%h expected v=1 s=%0d d=%h",
                     ov[0], os[0], od[0], nxt, in_data[nxt*W +: W]);
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] v_tab [7] = '{4'b0100, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1011, 4'b0011};
        logic [N-1:0] l_tab [7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b1011, 4'b0011};
        logic [N-1:0] r_tab [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        bit           e_v   [7] = '{1, 0, 0, 1, 1, 1, 1};
        int           e_s   [7] = '{2, 0, 0, 2, 2, 3, 0};
        bit           e_l   [7] = '{0, 0, 0, 0, 1, 1, 1};
        for (int c = 0; c < 7; c++) begin
            drive(v_tab[c], l_tab[c], 1'b1);
            #1;
            n_checks++;
            if (rdy[0] !== r_tab[c]) begin
                n_errors++;
                $display("FAIL lock_ready cycle%0d: got %b expected %b", c, rdy[0], r_tab[c]);
            end
            tick();
            n_checks++;
            if (ov[0] !== e_v[c] || (e_v[c] && (os[0] !== SELW'(e_s[c]) || ol[0] !== e_l[c]))) begin
                n_errors++;
                $display("FAIL lock_out cycle%0d: got v=%0b s=%0d l=%0b expected v=%0b s=%0d l=%0b",
                         c, ov[0], os[0], ol[0], e_v[c], e_s[c], e_l[c]);
            end
            n_checks++;
            if (ov[2] !== m_ov[2] || os[2] !== SELW'(m_os[2]) || ol[2] !== m_ol[2] || od[2] !== m_od[2]) begin
                n_errors++;
                $display("FAIL nolock_out cycle%0d: got v=%0b s=%0d l=%0b d=%h expected v=%0b s=%0d l=%0b d=%h",
                         c, ov[2], os[2], ol[2], od[2], m_ov[2], m_os[2], m_ol[2], m_od[2]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            #1;
            for (int k = 0; k < NI; k++) begin
                er = model_ready(k);
                n_checks++;
                if (rdy[k] !== er) begin
                    n_errors++;
                    $display("FAIL rand_ready inst%0d cycle%0d: got %b expected %b", k, c, rdy[k], er);
                end
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (ov[k] !== m_ov[k] || od[k] !== m_od[k] || ol[k] !== m_ol[k] || os[k] !== SELW'(m_os[k])) begin
                    n_errors++;
                    $display("FAIL rand_out inst%0d cycle%0d: got v=%0b d=%h l=%0b s=%0d expected v=%0b d=%h l=%0b s=%0d",
                             k, c, ov[k], od[k], ol[k], os[k], m_ov[k], m_od[k], m_ol[k], m_os[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(4'b0001, 4'b0000, 1'b1);
        tick();
        n_checks++;
        if (ov[0] !== 1'b1 || os[0] !== 2'd0) begin
            n_errors++;
            $display("FAIL arst_setup: got v=%0b s=%0d expected v=1 s=0", ov[0], os[0]);
        end
        drive(4'b0001, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (ov[k] !== 1'b0 || rdy[k] !== 4'b0000) begin
                n_errors++;
                $display("FAIL arst_immediate inst%0d: got v=%0b rdy=%b expected v=0 rdy=0000", k, ov[k], rdy[k]);
            end
        end
        tick();
        drive(4'b1110, 4'b1111, 1'b1);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 4'b0010) begin
            n_errors++;
            $display("FAIL arst_unlocked_ready: got %b expected 0010", rdy[0]);
        end
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (ov[k] !== 1'b1 || os[k] !== 2'd1 || od[k] !== in_data[W +: W]) begin
                n_errors++;
                $display("FAIL arst_first_beat inst%0d: got v=%0b s=%0d d=%h expected v=1 s=1 d=%h",
                         k, ov[k], os[k], od[k], in_data[W +: W]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_fixed();
        test_backpressure();
        test_lock();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
